// File: rtl/ttt_pkg.sv
// Shared encodings and state type for the tic-tac-toe board controller.
package ttt_pkg;

   localparam logic [1:0] CELL_EMPTY = 2'b00;
   localparam logic [1:0] CELL_P1    = 2'b01;
   localparam logic [1:0] CELL_P2    = 2'b10;
   localparam int         NUM_CELLS  = 9;

   typedef enum logic [1:0] {IDLE, WAIT_MOVE, CHECK, GAME_OVER} state_t;

   function automatic logic [1:0] other_player(input logic [1:0] p);
      return (p == CELL_P1) ? CELL_P2 : CELL_P1;
   endfunction

endpackage

// File: rtl/ttt_board_ctrl_turn_timer.sv
// Per-turn timer: counts while enabled, pulses expire on the last cycle of the
// allowance and wraps to zero by itself so a forfeited turn restarts cleanly.
module turn_timer #(
   parameter int TIMEOUT_CYCLES = 750000000,
   parameter int TIMER_W        = 30
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam logic [TIMER_W-1:0] LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

   logic [TIMER_W-1:0] timer_q, timer_d;

   // expire is not gated by clear; the controller gives start priority itself
   assign expire = enable && (timer_q == LAST);

   always_comb begin
      timer_d = timer_q;
      if (clear)
         timer_d = '0;
      else if (enable)
         timer_d = expire ? '0 : timer_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) timer_q <= '0;
      else     timer_q <= timer_d;
   end

endmodule

// File: rtl/ttt_board_ctrl.sv
// Tic-tac-toe game controller: board register, turn order, move legality and
// turn timeout. Define TTT_AUTO_MOVE_EN to auto-play the lowest empty cell on timeout.
module ttt_board_ctrl
   import ttt_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 750000000,
   parameter int TIMER_W        = 30
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       move_valid,
   input  logic [3:0] move_cell,
   output logic       move_ready,
   output logic       move_accept,
   output logic       move_reject,
   output logic       timeout,
   output logic [1:0] pos1,
   output logic [1:0] pos2,
   output logic [1:0] pos3,
   output logic [1:0] pos4,
   output logic [1:0] pos5,
   output logic [1:0] pos6,
   output logic [1:0] pos7,
   output logic [1:0] pos8,
   output logic [1:0] pos9,
   input  logic       winner_in,
   input  logic [1:0] who_in,
   output logic [1:0] turn,
   output logic [3:0] move_count,
   output logic       game_over,
   output logic       draw,
   output logic [1:0] result_who
);

   state_t                      state_q, state_d;
   logic [NUM_CELLS-1:0][1:0]   board_q, board_d;
   logic [1:0]                  turn_q, turn_d;
   logic [3:0]                  count_q, count_d;
   logic                        accept_q, accept_d;
   logic                        reject_q, reject_d;
   logic                        timeout_q, timeout_d;
   logic                        ready_q, ready_d;
   logic                        game_over_q, game_over_d;
   logic                        draw_q, draw_d;
   logic [1:0]                  result_q, result_d;

   logic expire;
   logic tgt_empty;
   logic legal;
`ifdef TTT_AUTO_MOVE_EN
   logic auto_done;
`endif

   turn_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .TIMER_W        (TIMER_W)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .clear  (start || (state_q != WAIT_MOVE)),
      .enable (state_q == WAIT_MOVE),
      .expire (expire)
   );

   // only cell numbers 1..9 can match, so out-of-range cells are never legal
   always_comb begin
      tgt_empty = 1'b0;
      for (int i = 0; i < NUM_CELLS; i++)
         if (move_cell == 4'(i + 1) && board_q[i] == CELL_EMPTY) tgt_empty = 1'b1;
   end

   assign legal = move_valid && tgt_empty;

   always_comb begin
      state_d     = state_q;
      board_d     = board_q;
      turn_d      = turn_q;
      count_d     = count_q;
      accept_d    = 1'b0;
      reject_d    = 1'b0;
      timeout_d   = 1'b0;
      game_over_d = game_over_q;
      draw_d      = draw_q;
      result_d    = result_q;
`ifdef TTT_AUTO_MOVE_EN
      auto_done   = 1'b0;
`endif
      if (start) begin
         board_d     = '0;
         turn_d      = CELL_P1;
         count_d     = 4'd0;
         game_over_d = 1'b0;
         draw_d      = 1'b0;
         result_d    = CELL_EMPTY;
         state_d     = WAIT_MOVE;
      end else begin
         case (state_q)
            WAIT_MOVE: begin
               if (legal) begin
                  for (int i = 0; i < NUM_CELLS; i++)
                     if (move_cell == 4'(i + 1)) board_d[i] = turn_q;
                  accept_d = 1'b1;
                  count_d  = count_q + 4'd1;
                  state_d  = CHECK;
               end else begin
                  reject_d = move_valid;
                  if (expire) begin
                     timeout_d = 1'b1;
`ifdef TTT_AUTO_MOVE_EN
                     for (int i = 0; i < NUM_CELLS; i++)
                        if (!auto_done && board_q[i] == CELL_EMPTY) begin
                           board_d[i] = turn_q;
                           auto_done  = 1'b1;
                        end
                     count_d = count_q + 4'd1;
                     state_d = CHECK;
`else
                     turn_d = other_player(turn_q);
`endif
                  end
               end
            end
            CHECK: begin
               if (winner_in) begin
                  result_d    = who_in;
                  game_over_d = 1'b1;
                  state_d     = GAME_OVER;
               end else if (count_q == 4'd9) begin
                  draw_d      = 1'b1;
                  game_over_d = 1'b1;
                  state_d     = GAME_OVER;
               end else begin
                  turn_d  = other_player(turn_q);
                  state_d = WAIT_MOVE;
               end
            end
            default: ;
         endcase
      end
      ready_d = (state_d == WAIT_MOVE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         board_q     <= '0;
         turn_q      <= CELL_P1;
         count_q     <= 4'd0;
         accept_q    <= 1'b0;
         reject_q    <= 1'b0;
         timeout_q   <= 1'b0;
         ready_q     <= 1'b0;
         game_over_q <= 1'b0;
         draw_q      <= 1'b0;
         result_q    <= CELL_EMPTY;
      end else begin
         state_q     <= state_d;
         board_q     <= board_d;
         turn_q      <= turn_d;
         count_q     <= count_d;
         accept_q    <= accept_d;
         reject_q    <= reject_d;
         timeout_q   <= timeout_d;
         ready_q     <= ready_d;
         game_over_q <= game_over_d;
         draw_q      <= draw_d;
         result_q    <= result_d;
      end
   end

   assign move_ready  = ready_q;
   assign move_accept = accept_q;
   assign move_reject = reject_q;
   assign timeout     = timeout_q;
   assign turn        = turn_q;
   assign move_count  = count_q;
   assign game_over   = game_over_q;
   assign draw        = draw_q;
   assign result_who  = result_q;
   assign pos1 = board_q[0];
   assign pos2 = board_q[1];
   assign pos3 = board_q[2];
   assign pos4 = board_q[3];
   assign pos5 = board_q[4];
   assign pos6 = board_q[5];
   assign pos7 = board_q[6];
   assign pos8 = board_q[7];
   assign pos9 = board_q[8];

endmodule

// File: tb/tb_ttt_board_ctrl.sv
// Scoreboard bench for ttt_board_ctrl with a behavioural winner detector;
// pulse expectations are queued by stimulus and retired by a negedge monitor.
module tb_ttt_board_ctrl;

   logic       clk = 1'b0;
   logic       rst, start, move_valid;
   logic [3:0] move_cell;
   logic       move_ready, move_accept, move_reject, timeout;
   logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9;
   logic       winner_in;
   logic [1:0] who_in, turn, result_who;
   logic [3:0] move_count;
   logic       game_over, draw;

   always #5 clk = ~clk;

   ttt_board_ctrl #(.TIMEOUT_CYCLES(10), .TIMER_W(4)) dut (
      .clk(clk), .rst(rst), .start(start), .move_valid(move_valid), .move_cell(move_cell),
      .move_ready(move_ready), .move_accept(move_accept), .move_reject(move_reject),
      .timeout(timeout), .pos1(pos1), .pos2(pos2), .pos3(pos3), .pos4(pos4), .pos5(pos5),
      .pos6(pos6), .pos7(pos7), .pos8(pos8), .pos9(pos9), .winner_in(winner_in),
      .who_in(who_in), .turn(turn), .move_count(move_count), .game_over(game_over),
      .draw(draw), .result_who(result_who)
   );

   // behavioural winner detector
   function automatic logic [1:0] ln(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
      return (a != 2'b00 && a == b && b == c) ? a : 2'b00;
   endfunction

   logic [1:0] lw [8];
   always_comb begin
      lw[0] = ln(pos1, pos2, pos3); lw[1] = ln(pos4, pos5, pos6); lw[2] = ln(pos7, pos8, pos9);
      lw[3] = ln(pos1, pos4, pos7); lw[4] = ln(pos2, pos5, pos8); lw[5] = ln(pos3, pos6, pos9);
      lw[6] = ln(pos1, pos5, pos9); lw[7] = ln(pos3, pos5, pos7);
      winner_in = 1'b0;
      who_in    = 2'b00;
      for (int i = 0; i < 8; i++)
         if (!winner_in && lw[i] != 2'b00) begin
            winner_in = 1'b1;
            who_in    = lw[i];
         end
   end

   wire [17:0] allpos = {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1};

   typedef struct packed { logic acc; logic rej; logic tmo; } ev_t;
   ev_t exp_q[$];
   int  tests = 0;
   int  fails = 0;

   always @(negedge clk) begin
      if (!rst && (move_accept || move_reject || timeout)) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL pulse: got acc/rej/tmo=%b%b%b, required no pulse",
                     move_accept, move_reject, timeout);
         end else begin
            ev_t e;
            e = exp_q.pop_front();
            if ({move_accept, move_reject, timeout} !== e) begin
               fails++;
               $display("FAIL pulse: got acc/rej/tmo=%b%b%b, required %b",
                        move_accept, move_reject, timeout, e);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      @(negedge clk);
      while (!move_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!move_ready) begin
         tests++;
         fails++;
         $display("FAIL ready_wait: move_ready got 0, required 1 within 40 cycles");
      end
   endtask

   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic mv(input logic [3:0] c, input bit legal, input bit hold);
      ev_t e;
      wait_ready();
      e = legal ? 3'b100 : 3'b010;
      exp_q.push_back(e);
      move_valid = 1'b1;
      move_cell  = c;
      @(posedge clk);
      #1;
      if (hold) begin
         move_cell = 4'd9;
         @(posedge clk);
         #1;
      end
      move_valid = 1'b0;
   endtask

   task automatic settle();
      repeat (3) @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; move_valid = 1'b0; move_cell = 4'd0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_pos", 32'(allpos), 32'h0);
      chk("reset_turn", 32'(turn), 32'h1);
      chk("reset_count", 32'(move_count), 32'h0);
      chk("reset_flags", 32'({move_ready, game_over, draw, result_who}), 32'h0);

      // row win for player 1
      do_start();
      mv(4'd1, 1, 0);
      wait_ready();
      chk("turn_after_p1", 32'(turn), 32'h2);
      chk("pos1_after_p1", 32'(pos1), 32'h1);
      mv(4'd4, 1, 0); mv(4'd2, 1, 0); mv(4'd5, 1, 0); mv(4'd3, 1, 0);
      settle();
      chk("win_result", 32'(result_who), 32'h1);
      chk("win_game_over", 32'(game_over), 32'h1);
      chk("win_count", 32'(move_count), 32'h5);
      chk("win_row", 32'({pos3, pos2, pos1}), 32'h15);
      chk("win_draw", 32'(draw), 32'h0);
      chk("win_ready", 32'(move_ready), 32'h0);

      // illegal moves and move_valid during CHECK
      do_start();
      mv(4'd5, 1, 0);
      mv(4'd5, 0, 0);
      wait_ready();
      chk("occupied_turn", 32'(turn), 32'h2);
      chk("occupied_pos5", 32'(pos5), 32'h1);
      chk("occupied_count", 32'(move_count), 32'h1);
      mv(4'd0, 0, 0);
      mv(4'd12, 0, 0);
      mv(4'd1, 1, 1);
      settle();
      chk("check_ignore_pos9", 32'(pos9), 32'h0);
      chk("p2_pos1", 32'(pos1), 32'h2);
      chk("illegal_turn", 32'(turn), 32'h1);
      chk("illegal_count", 32'(move_count), 32'h2);

      // draw
      do_start();
      mv(4'd1, 1, 0); mv(4'd2, 1, 0); mv(4'd3, 1, 0); mv(4'd5, 1, 0); mv(4'd4, 1, 0);
      mv(4'd6, 1, 0); mv(4'd8, 1, 0); mv(4'd7, 1, 0); mv(4'd9, 1, 0);
      settle();
      chk("draw_flag", 32'(draw), 32'h1);
      chk("draw_result", 32'(result_who), 32'h0);
      chk("draw_count", 32'(move_count), 32'h9);
      chk("draw_game_over", 32'(game_over), 32'h1);

      // start beats a move in GAME_OVER
      @(negedge clk);
      start = 1'b1; move_valid = 1'b1; move_cell = 4'd1;
      @(posedge clk);
      #1 start = 1'b0; move_valid = 1'b0;
      @(negedge clk);
      chk("restart_pos", 32'(allpos), 32'h0);
      chk("restart_turn", 32'(turn), 32'h1);
      chk("restart_ready", 32'(move_ready), 32'h1);
      chk("restart_flags", 32'({game_over, draw, result_who}), 32'h0);

      // idle timeout, counted from the restart edge
      exp_q.push_back(3'b001);
      repeat (10) @(negedge clk);
      @(negedge clk);
      chk("timeout_turn", 32'(turn), 32'h2);
`ifdef TTT_AUTO_MOVE_EN
      chk("timeout_pos1", 32'(pos1), 32'h1);
      chk("timeout_count", 32'(move_count), 32'h1);
`else
      chk("timeout_pos", 32'(allpos), 32'h0);
      chk("timeout_count", 32'(move_count), 32'h0);
`endif

      // legal move on the expiry cycle: accept only
      do_start();
      repeat (10) @(negedge clk);
      exp_q.push_back(3'b100);
      move_valid = 1'b1; move_cell = 4'd5;
      @(posedge clk);
      #1 move_valid = 1'b0;
      settle();
      chk("expiry_move_pos5", 32'(pos5), 32'h1);
      chk("expiry_move_turn", 32'(turn), 32'h2);
      chk("expiry_move_count", 32'(move_count), 32'h1);

      // illegal move on the expiry cycle: reject and timeout together
      do_start();
      repeat (10) @(negedge clk);
      exp_q.push_back(3'b011);
      move_valid = 1'b1; move_cell = 4'd0;
      @(posedge clk);
      #1 move_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("expiry_reject_turn", 32'(turn), 32'h2);
      chk("expiry_reject_ready", 32'(move_ready), 32'h1);
`ifdef TTT_AUTO_MOVE_EN
      chk("expiry_reject_pos1", 32'(pos1), 32'h1);
`else
      chk("expiry_reject_pos1", 32'(pos1), 32'h0);
`endif

      // asynchronous reset mid-game
      do_start();
      mv(4'd1, 1, 0); mv(4'd2, 1, 0); mv(4'd3, 1, 0);
      wait_ready();
      #3 rst = 1'b1;
      #1;
      chk("async_rst_pos", 32'(allpos), 32'h0);
      chk("async_rst_turn", 32'(turn), 32'h1);
      chk("async_rst_count", 32'(move_count), 32'h0);
      chk("async_rst_flags", 32'({move_ready, game_over, draw, result_who}), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      move_valid = 1'b1; move_cell = 4'd4;
      @(posedge clk);
      #1 move_valid = 1'b0;
      settle();
      chk("idle_ignore_pos4", 32'(pos4), 32'h0);
      chk("idle_ready", 32'(move_ready), 32'h0);

      chk("pending_pulses", 32'(exp_q.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ttt_board_ctrl.md
Name: ttt_board_ctrl

Overview:
- Upstream game controller for the tic-tac-toe datapath.
- Holds the registered 3x3 board and alternates turns. Accepts or rejects player moves and enforces a per-turn timeout.
- Drives pos1..pos9 into winner_detector and consumes its winner/who outputs to decide win, draw or continue.
- Its outputs feed the display and LED logic.

Parameters:
- TIMEOUT_CYCLES, 750000000: cycles allowed per turn before timeout (15 s at 50 MHz).
- TIMER_W, 30: turn timer width; must satisfy 2^TIMER_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous and active-high; one clock domain only.
- start  in  1  one-cycle pulse; clears the board and (re)starts a game.
- move_valid  in  1  player presents a move this cycle.
- move_cell  in  4  target cell, 1..9, row-major.
- move_ready  out  1  high only in WAIT_MOVE.
- move_accept  out  1  one-cycle pulse; the move was written.
- move_reject  out  1  one-cycle pulse; the move was illegal.
- timeout  out  1  one-cycle pulse; the turn timer expired.
- pos1..pos9  out  2 each  board cells to winner_detector. 00 = empty, 01 = player 1, 10 = player 2.
- winner_in  in  1  from winner_detector.winner.
- who_in  in  2  from winner_detector.who.
- turn  out  2  player to move: 01 or 10.
- move_count  out  4  marks placed, 0..9.
- game_over  out  1  level; high in GAME_OVER.
- draw  out  1  level; board full with no winner.
- result_who  out  2  winning player; 00 when draw or no result.

Behaviour:
- Reset values: all pos = 00, state = IDLE, turn = 01, move_count = 0, timer = 0. All pulses, game_over, draw = 0; result_who = 00.
- All outputs are registered.
- States: IDLE, WAIT_MOVE, CHECK, GAME_OVER.
- start in any state:
  - clears the board, sets turn = 01, move_count = 0, timer = 0, draw = 0, game_over = 0, result_who = 00;
  - next state is WAIT_MOVE;
  - start has priority over any move or timeout in the same cycle.
- IDLE: waits for start only.
- WAIT_MOVE, timer: increments every cycle.
- WAIT_MOVE, legal move (move_valid with move_cell in 1..9 and the cell == 00):
  - cell <= turn; move_accept pulses; move_count++; next state CHECK.
- WAIT_MOVE, illegal move (move_cell = 0, move_cell > 9, or cell occupied):
  - move_reject pulses; board unchanged; timer not cleared; stay in WAIT_MOVE.
- WAIT_MOVE, expiry: when the timer reaches TIMEOUT_CYCLES-1 without a legal move, timeout pulses and the timeout action (see Optional Feature) applies.
- Legal move and expiry in the same cycle: the move is taken; no timeout pulse.
- Illegal move and expiry in the same cycle: reject and timeout both pulse.
- CHECK: exactly one cycle; winner_detector evaluates the updated board combinationally.
  - winner_in = 1: result_who <= who_in, game_over <= 1, next state GAME_OVER.
  - else move_count = 9: draw <= 1, game_over <= 1, next state GAME_OVER.
  - else: turn toggles 01 <-> 10, timer <= 0, next state WAIT_MOVE.
- move_valid is ignored in CHECK, IDLE and GAME_OVER; neither accept nor reject pulses.
- Latency: a move accepted at edge N shows on pos at N+1. game_over or the turn toggle is visible at N+2. move_ready is high again at N+2.
- GAME_OVER: board, result_who and draw are frozen until start or rst.
- A winner on the 9th move reports the win, not a draw.
- rst mid-game returns to the reset values immediately (asynchronous).

Optional Feature:
- Macro: TTT_AUTO_MOVE_EN.
- Defined: on timeout, turn is written into the lowest-index empty cell; move_count++; next state CHECK; move_accept does not pulse.
  - At least one cell is always empty in WAIT_MOVE.
- Undefined: on timeout the turn is forfeited. turn toggles, timer <= 0, board and move_count unchanged, stay in WAIT_MOVE.

Decomposition:
- Package ttt_pkg:
  - cell encodings: CELL_EMPTY = 2'b00, CELL_P1 = 2'b01, CELL_P2 = 2'b10;
  - NUM_CELLS = 9;
  - state enum {IDLE, WAIT_MOVE, CHECK, GAME_OVER}.
- Sub-module turn_timer: clear and enable inputs, a one-cycle expire output; parameterised by TIMEOUT_CYCLES and TIMER_W.
- The board is stored internally as an array of 9 cells.

Test Plan:
- Row win: start, then moves 1, 4, 2, 5, 3 → P1 wins on row 1-2-3. result_who = 01, game_over = 1, move_count = 5, pos1..pos3 = 01.
- Illegal moves:
  - move to cell 5 after cell 5 is already taken → move_reject pulse, board unchanged, turn unchanged;
  - move_cell = 0 and move_cell = 12 → reject;
  - move_valid during CHECK → no pulse.
- Draw: moves 1, 2, 3, 5, 4, 6, 8, 7, 9 → draw = 1, result_who = 00, move_count = 9, game_over = 1.
- Timeout with TIMEOUT_CYCLES = 10 and no input:
  - with TTT_AUTO_MOVE_EN, after 10 cycles: timeout pulse, pos1 = 01, turn becomes 10;
  - without it: timeout pulse, board empty, turn = 10.
- Restart and priority:
  - start asserted while move_valid is high in GAME_OVER → board all 00, turn = 01, WAIT_MOVE;
  - a legal move and expiry in the same cycle → accept only, no timeout pulse.
- Reset mid-game: assert rst asynchronously after 3 moves → all outputs at reset values immediately, state IDLE.
